// File: rtl/flow_step_ctrl.sv
// Button front end for the LED chaser: sync, debounce, speed/pause/dir state, step strobe.
// Define FLOW_SINGLE_STEP_EN to make a speed press while paused issue one manual step.
module flow_step_ctrl #(
   parameter int CLK_FREQ    = 50_000_000,
   parameter int DEBOUNCE_MS = 20
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic [2:0] key,
   output logic       step_pulse,
   output logic       step_dir,
   output logic [1:0] speed_sel,
   output logic       paused
);

   localparam int DB_CNT = (CLK_FREQ / 1000) * DEBOUNCE_MS;
   localparam int DBW    = $clog2(DB_CNT);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CNT - 1);
   localparam logic [27:0]    BASE    = 28'(CLK_FREQ);

   logic [2:0]     sync1;
   logic [2:0]     sync2;
   logic [2:0]     stable;
   logic [2:0]     stable_q;
   logic [2:0]     press;
   logic [DBW-1:0] db_cnt [3];

   logic [27:0] tcnt;
   logic [27:0] tcnt_nx;
   logic [27:0] period;
   logic        term;
   logic        spd_step;
   logic        spd_adv;
   logic        pulse_nx;
   logic [1:0]  speed_nx;
   logic        paused_nx;
   logic        dir_nx;

   // Keys idle high; a press is the registered falling edge of the debounced level.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         sync1    <= '1;
         sync2    <= '1;
         stable   <= '1;
         stable_q <= '1;
         press    <= '0;
         for (int i = 0; i < 3; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync1    <= key;
         sync2    <= sync1;
         stable_q <= stable;
         press    <= stable_q & ~stable;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      period    = BASE >> speed_sel;
      term      = (tcnt == period - 28'd1);
      spd_step  = 1'b0;
`ifdef FLOW_SINGLE_STEP_EN
      spd_step  = press[0] & paused;
`else
      spd_step  = 1'b0;
`endif
      spd_adv   = press[0] & ~spd_step & (speed_sel != 2'd3);
      speed_nx  = speed_sel + {1'b0, spd_adv};
      paused_nx = paused ^ press[1];
      dir_nx    = step_dir ^ press[2];
      tcnt_nx   = tcnt;
      pulse_nx  = spd_step;
      // Speed clear beats terminal count; a pause press freezes the count on its own edge.
      if (spd_adv) begin
         tcnt_nx = '0;
      end else if (!paused && !press[1]) begin
         if (term) begin
            tcnt_nx  = '0;
            pulse_nx = 1'b1;
         end else begin
            tcnt_nx = tcnt + 28'd1;
         end
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         tcnt       <= '0;
         step_pulse <= 1'b0;
         speed_sel  <= '0;
         paused     <= 1'b0;
         step_dir   <= 1'b0;
      end else begin
         tcnt       <= tcnt_nx;
         step_pulse <= pulse_nx;
         speed_sel  <= speed_nx;
         paused     <= paused_nx;
         step_dir   <= dir_nx;
      end
   end

endmodule

// File: tb/tb_flow_step_ctrl.sv
// Directed bench for flow_step_ctrl at CLK_FREQ=16000, DEBOUNCE_MS=1 (DB_CNT=16).
// Key-to-state latency is 20 cycles; cyc counts rising edges since reset release.
module tb_flow_step_ctrl;

   localparam int P0  = 16000;
   localparam int LAT = 20;

   logic       sys_clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] key = 3'b111;
   logic       step_pulse;
   logic       step_dir;
   logic [1:0] speed_sel;
   logic       paused;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int npulse = 0;
   int last_pulse = -1;
   int s_evt = 0;

   flow_step_ctrl #(
      .CLK_FREQ(16000),
      .DEBOUNCE_MS(1)
   ) dut (
      .sys_clk(sys_clk),
      .rst(rst),
      .key(key),
      .step_pulse(step_pulse),
      .step_dir(step_dir),
      .speed_sel(speed_sel),
      .paused(paused)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= rst ? 0 : cyc + 1;

   always @(negedge sys_clk) begin
      if (!rst && step_pulse) begin
         npulse++;
         last_pulse = cyc;
      end
   end

   task automatic tick();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      key = 3'b111;
      repeat (3) tick();
      checks++;
      if ({step_pulse, step_dir, speed_sel, paused} !== 5'b0) begin
         errors++;
         $display("FAIL reset_hold: got %b want 00000",
                  {step_pulse, step_dir, speed_sel, paused});
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({step_pulse, step_dir, speed_sel, paused} !== 5'b0) begin
         errors++;
         $display("FAIL reset_release: got %b want 00000",
                  {step_pulse, step_dir, speed_sel, paused});
      end
   endtask

   task automatic test_free_run();
      int n0;
      n0 = npulse;
      wait_until(P0 - 1);
      checks++;
      if (npulse !== n0) begin
         errors++;
         $display("FAIL first_no_early: pulses %0d want %0d", npulse, n0);
      end
      tick();
      checks++;
      if (npulse !== n0 + 1 || last_pulse !== P0) begin
         errors++;
         $display("FAIL first_pulse: at %0d n=%0d want %0d", last_pulse, npulse, P0);
      end
      wait_until(2 * P0);
      checks++;
      if (npulse !== n0 + 2 || last_pulse !== 2 * P0) begin
         errors++;
         $display("FAIL second_pulse: at %0d n=%0d want %0d", last_pulse, npulse, 2 * P0);
      end
      checks++;
      if ({step_dir, speed_sel, paused} !== 4'b0) begin
         errors++;
         $display("FAIL idle_state: got %b want 0000", {step_dir, speed_sel, paused});
      end
   endtask

   task automatic test_speed_debounce();
      int k;
      int n;
      for (int b = 0; b < 4; b++) begin
         key[0] = b[0];
         tick();
      end
      key[0] = 1'b0;
      k = cyc;
      wait_until(k + LAT - 1);
      checks++;
      if (speed_sel !== 2'd0) begin
         errors++;
         $display("FAIL speed_early: got %0d want 0", speed_sel);
      end
      tick();
      checks++;
      if (speed_sel !== 2'd1) begin
         errors++;
         $display("FAIL speed_latency: got %0d want 1 at cycle %0d", speed_sel, cyc);
      end
      s_evt = k + LAT;
      wait_until(k + 40);
      for (int b = 0; b < 4; b++) begin
         key[0] = ~b[0];
         tick();
      end
      key[0] = 1'b1;
      repeat (30) tick();
      n = npulse;
      wait_until(s_evt + 7999);
      checks++;
      if (npulse !== n) begin
         errors++;
         $display("FAIL speed_no_early: pulses %0d want %0d", npulse, n);
      end
      tick();
      checks++;
      if (npulse !== n + 1 || last_pulse !== s_evt + 8000) begin
         errors++;
         $display("FAIL speed_spacing: at %0d want %0d", last_pulse, s_evt + 8000);
      end
      checks++;
      if (speed_sel !== 2'd1) begin
         errors++;
         $display("FAIL speed_single_event: got %0d want 1", speed_sel);
      end
   endtask

   task automatic test_simultaneous();
      int e;
      int n0;
      int k2;
      int r;
      e = last_pulse + 8000;
      wait_until(e - LAT);
      key[1:0] = 2'b00;
      n0 = npulse;
      wait_until(e);
      checks++;
      if (speed_sel !== 2'd2 || paused !== 1'b1) begin
         errors++;
         $display("FAIL simul_state: spd=%0d paused=%0d want 2 1", speed_sel, paused);
      end
      checks++;
      if (npulse !== n0) begin
         errors++;
         $display("FAIL simul_no_pulse: pulses %0d want %0d", npulse, n0);
      end
      wait_until(e + 10);
      key[1:0] = 2'b11;
      wait_until(e + 40);
      key[1] = 1'b0;
      k2 = cyc;
      r = k2 + LAT;
      wait_until(r);
      checks++;
      if (paused !== 1'b0) begin
         errors++;
         $display("FAIL simul_resume: paused %0d want 0", paused);
      end
      wait_until(k2 + 30);
      key[1] = 1'b1;
      wait_until(r + 3999);
      checks++;
      if (npulse !== n0) begin
         errors++;
         $display("FAIL simul_hold: pulses %0d want %0d", npulse, n0);
      end
      tick();
      checks++;
      if (npulse !== n0 + 1 || last_pulse !== r + 4000) begin
         errors++;
         $display("FAIL simul_tcnt_zero: at %0d want %0d", last_pulse, r + 4000);
      end
   endtask

   task automatic test_saturate();
      int k;
      int n;
      int a;
      for (int i = 0; i < 3; i++) begin
         key[0] = 1'b0;
         k = cyc;
         wait_until(k + LAT);
         checks++;
         if (speed_sel !== 2'd3) begin
            errors++;
            $display("FAIL sat_press%0d: got %0d want 3", i, speed_sel);
         end
         wait_until(k + 30);
         key[0] = 1'b1;
         wait_until(k + 60);
      end
      n = npulse;
      a = -1;
      for (int i = 0; i < 5000 && npulse < n + 2; i++) begin
         tick();
         if (npulse == n + 1 && a < 0) a = last_pulse;
      end
      checks++;
      if (npulse !== n + 2 || last_pulse - a !== 2000) begin
         errors++;
         $display("FAIL sat_spacing: gap %0d n=%0d want 2000", last_pulse - a, npulse - n);
      end
   endtask

   task automatic test_pause();
      int k;
      int e;
      int n;
      int k2;
      int r;
      k = last_pulse + 981;
      wait_until(k);
      key[1] = 1'b0;
      e = k + LAT;
      wait_until(e - 1);
      checks++;
      if (paused !== 1'b0) begin
         errors++;
         $display("FAIL pause_early: got %0d want 0", paused);
      end
      tick();
      checks++;
      if (paused !== 1'b1) begin
         errors++;
         $display("FAIL pause_set: got %0d want 1", paused);
      end
      wait_until(k + 30);
      key[1] = 1'b1;
      n = npulse;
      wait_until(e + 10000);
      checks++;
      if (npulse !== n || paused !== 1'b1) begin
         errors++;
         $display("FAIL pause_hold: pulses %0d paused %0d want %0d 1", npulse, paused, n);
      end
      key[1] = 1'b0;
      k2 = cyc;
      r = k2 + LAT;
      wait_until(r);
      checks++;
      if (paused !== 1'b0) begin
         errors++;
         $display("FAIL pause_resume: got %0d want 0", paused);
      end
      wait_until(k2 + 30);
      key[1] = 1'b1;
      wait_until(r + 999);
      checks++;
      if (npulse !== n) begin
         errors++;
         $display("FAIL resume_no_early: pulses %0d want %0d", npulse, n);
      end
      tick();
      checks++;
      if (npulse !== n + 1 || last_pulse !== r + 1000) begin
         errors++;
         $display("FAIL resume_remaining: at %0d want %0d", last_pulse, r + 1000);
      end
   endtask

   task automatic test_direction();
      int lp;
      int k;
      lp = last_pulse;
      key[2] = 1'b0;
      k = cyc;
      wait_until(k + LAT);
      checks++;
      if (step_dir !== 1'b1) begin
         errors++;
         $display("FAIL dir_set: got %0d want 1", step_dir);
      end
      wait_until(k + 30);
      key[2] = 1'b1;
      wait_until(lp + 2000);
      checks++;
      if (last_pulse !== lp + 2000) begin
         errors++;
         $display("FAIL dir_cadence: at %0d want %0d", last_pulse, lp + 2000);
      end
      key[2] = 1'b0;
      k = cyc;
      wait_until(k + LAT);
      checks++;
      if (step_dir !== 1'b0) begin
         errors++;
         $display("FAIL dir_clear: got %0d want 0", step_dir);
      end
      wait_until(k + 30);
      key[2] = 1'b1;
      repeat (30) tick();
   endtask

   task automatic test_reset_mid();
      int k;
      int n;
      key[1] = 1'b0;
      k = cyc;
      wait_until(k + 10);
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({step_pulse, step_dir, speed_sel, paused} !== 5'b0) begin
         errors++;
         $display("FAIL reset_mid: got %b want 00000",
                  {step_pulse, step_dir, speed_sel, paused});
      end
      rst = 1'b0;
      repeat (12) tick();
      key[1] = 1'b1;
      n = npulse;
      repeat (100) tick();
      checks++;
      if (paused !== 1'b0 || speed_sel !== 2'd0 || npulse !== n) begin
         errors++;
         $display("FAIL reset_discard: paused %0d spd %0d pulses %0d want 0 0 %0d",
                  paused, speed_sel, npulse, n);
      end
   endtask

   task automatic test_single_step();
      int k;
      int n;
      key[1] = 1'b0;
      k = cyc;
      wait_until(k + LAT);
      checks++;
      if (paused !== 1'b1) begin
         errors++;
         $display("FAIL ss_paused: got %0d want 1", paused);
      end
      wait_until(k + 30);
      key[1] = 1'b1;
      wait_until(k + 60);
      n = npulse;
      key[0] = 1'b0;
      k = cyc;
      wait_until(k + LAT);
      checks++;
`ifdef FLOW_SINGLE_STEP_EN
      if (speed_sel !== 2'd0 || npulse !== n + 1 || last_pulse !== k + LAT) begin
         errors++;
         $display("FAIL ss_step: spd %0d pulses %0d at %0d want 0 %0d %0d",
                  speed_sel, npulse - n, last_pulse, 1, k + LAT);
      end
`else
      if (speed_sel !== 2'd1 || npulse !== n) begin
         errors++;
         $display("FAIL ss_step: spd %0d pulses %0d want 1 0", speed_sel, npulse - n);
      end
`endif
      wait_until(k + 30);
      key[0] = 1'b1;
      wait_until(k + 100);
      checks++;
`ifdef FLOW_SINGLE_STEP_EN
      if (npulse !== n + 1) begin
         errors++;
         $display("FAIL ss_once: pulses %0d want 1", npulse - n);
      end
`else
      if (npulse !== n) begin
         errors++;
         $display("FAIL ss_once: pulses %0d want 0", npulse - n);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_speed_debounce();
      test_simultaneous();
      test_saturate();
      test_pause();
      test_direction();
      test_reset_mid();
      test_single_step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
